// File: rtl/alu_control_pkg.sv
// rtl/alu_control_pkg.sv - shared ALU operation encodings, width default and buffer states
package alu_control_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_XOR  = 4'd3,
        OP_OR   = 4'd4,
        OP_AND  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_LT   = 4'd9,
        OP_LTU  = 4'd10,
        OP_EQ   = 4'd11,
        OP_GTE  = 4'd12,
        OP_GTEU = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    // NOP and unassigned codes must never resolve a branch as taken.
    function automatic logic op_defined(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd13);
    endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// rtl/execute_stage_alu.sv - combinational ALU used by the execute stage
module alu
    import alu_control_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    logic [4:0] w_shamt;

    assign w_shamt = b[4:0];

    always_comb begin
        result = '0;
        case (alu_op_e'(op))
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_XOR:  result = a ^ b;
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_SLL:  result = a << w_shamt;
            OP_SRL:  result = a >> w_shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> w_shamt);
            OP_LT:   result = {{(DATA_W-1){1'b0}}, $signed(a) <  $signed(b)};
            OP_LTU:  result = {{(DATA_W-1){1'b0}}, a <  b};
            OP_EQ:   result = {{(DATA_W-1){1'b0}}, a == b};
            OP_GTE:  result = {{(DATA_W-1){1'b0}}, $signed(a) >= $signed(b)};
            OP_GTEU: result = {{(DATA_W-1){1'b0}}, a >= b};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage with ALU and two-entry main/skid output buffer
module execute_stage
    import alu_control_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_is_branch,
    input  logic              in_invert,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_branch_taken,
    output logic [RD_W-1:0]   out_rd
);

    buf_state_e        r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_main_result;
    logic              r_main_taken;
    logic [RD_W-1:0]   r_main_rd;
    logic [DATA_W-1:0] r_skid_result;
    logic              r_skid_taken;
    logic [RD_W-1:0]   r_skid_rd;

    logic [DATA_W-1:0] w_result;
    logic              w_taken;
    logic              w_accept;
    logic              w_deliver;

    alu #(.DATA_W(DATA_W)) u_alu (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .result (w_result)
    );

    assign w_taken   = in_is_branch & op_defined(in_op) & (w_result[0] ^ in_invert);
    assign w_accept  = in_valid & r_in_ready & ~flush;
    assign w_deliver = r_out_valid & out_ready;

    // in_ready and out_valid are registered alongside the state so both are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_EMPTY;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_main_result <= '0;
            r_main_taken  <= 1'b0;
            r_main_rd     <= '0;
            r_skid_result <= '0;
            r_skid_taken  <= 1'b0;
            r_skid_rd     <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main_result <= w_result;
                        r_main_taken  <= w_taken;
                        r_main_rd     <= in_rd;
                        r_out_valid   <= 1'b1;
                        r_state       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_deliver) begin
                        r_main_result <= w_result;
                        r_main_taken  <= w_taken;
                        r_main_rd     <= in_rd;
                    end else if (w_accept) begin
                        r_skid_result <= w_result;
                        r_skid_taken  <= w_taken;
                        r_skid_rd     <= in_rd;
                        r_in_ready    <= 1'b0;
                        r_state       <= ST_TWO;
                    end else if (w_deliver) begin
                        r_out_valid   <= 1'b0;
                        r_state       <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_deliver) begin
                        r_main_result <= r_skid_result;
                        r_main_taken  <= r_skid_taken;
                        r_main_rd     <= r_skid_rd;
                        r_in_ready    <= 1'b1;
                        r_state       <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready         = r_in_ready;
    assign out_valid        = r_out_valid;
    assign out_result       = r_main_result;
    assign out_branch_taken = r_main_taken;
    assign out_rd           = r_main_rd;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - scoreboard bench for execute_stage
module tb_execute_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_is_branch;
    logic        in_invert;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_branch_taken;
    logic [4:0]  out_rd;

    typedef struct {
        logic [31:0] res;
        logic        tk;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;
    int   checks = 0;
    int   errors = 0;

    logic        hold_v = 1'b0;
    logic [31:0] h_res;
    logic        h_tk;
    logic [4:0]  h_rd;

    execute_stage #(.DATA_W(32), .RD_W(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_op            (in_op),
        .in_a             (in_a),
        .in_b             (in_b),
        .in_is_branch     (in_is_branch),
        .in_invert        (in_invert),
        .in_rd            (in_rd),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_branch_taken (out_branch_taken),
        .out_rd           (out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference ALU written independently of the RTL (sign handled by hand).
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  s;
        logic        lt_s;
        logic [31:0] fill;
        s    = b[4:0];
        lt_s = (a[31] != b[31]) ? a[31] : (a < b);
        fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
        case (op)
            4'd1:    return a + b;
            4'd2:    return a + ~b + 32'd1;
            4'd3:    return a ^ b;
            4'd4:    return a | b;
            4'd5:    return a & b;
            4'd6:    return a << s;
            4'd7:    return a >> s;
            4'd8:    return (a >> s) | fill;
            4'd9:    return {31'd0, lt_s};
            4'd10:   return {31'd0, a < b};
            4'd11:   return {31'd0, a == b};
            4'd12:   return {31'd0, ~lt_s};
            4'd13:   return {31'd0, ~(a < b)};
            default: return 32'd0;
        endcase
    endfunction

    // Monitor: pops and compares whenever the DUT delivers.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_result", out_result, h_res);
                chk("hold_taken", {31'd0, out_branch_taken}, {31'd0, h_tk});
                chk("hold_rd", {27'd0, out_rd}, {27'd0, h_rd});
            end
            chk("occupancy", {31'd0, out_valid}, {31'd0, sb.size() != 0});
            if (out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got rd %0d result %h, required none", out_rd, out_result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", out_result, e.res);
                    chk("taken", {31'd0, out_branch_taken}, {31'd0, e.tk});
                    chk("rd", {27'd0, out_rd}, {27'd0, e.rd});
                end
            end
            hold_v = out_valid && !out_ready && !flush;
            h_res  = out_result;
            h_tk   = out_branch_taken;
            h_rd   = out_rd;
        end
    end

    task automatic step(output logic acc);
        logic fl;
        @(negedge clk);
        acc = in_valid && in_ready && !flush && rst_n;
        fl  = flush;
        @(posedge clk);
        if (fl) sb.delete();
        else if (acc) sb.push_back(cur_exp);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic br, input logic inv, input logic [4:0] rd,
                        input logic [31:0] res, input logic tk);
        logic acc;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        in_is_branch = br; in_invert = inv; in_rd = rd;
        cur_exp.res = res; cur_exp.tk = tk; cur_exp.rd = rd;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) step(acc);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: rd %0d not accepted, required acceptance", rd);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   accepted;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_a = '0; in_b = '0;
        in_is_branch = 1'b0; in_invert = 1'b0; in_rd = '0; flush = 1'b0; out_ready = 1'b1;
        cur_exp = '{res: 32'd0, tk: 1'b0, rd: 5'd0};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_result", out_result, 32'd0);
        chk("reset_taken", {31'd0, out_branch_taken}, 32'd0);
        chk("reset_rd", {27'd0, out_rd}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Directed vectors, out_ready high.
        send(4'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 5'd3, 32'h0000_0000, 1'b0);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        send(4'd8, 32'h8000_0000, 32'h0000_0024, 1'b0, 1'b0, 5'd4, 32'hF800_0000, 1'b0);
        send(4'd7, 32'h8000_0000, 32'h0000_0024, 1'b0, 1'b0, 5'd5, 32'h0800_0000, 1'b0);
        send(4'd11, 32'd5, 32'd5, 1'b1, 1'b1, 5'd6, 32'd1, 1'b0);
        send(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 5'd7, 32'd1, 1'b1);
        send(4'd10, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 5'd8, 32'd0, 1'b0);
        send(4'd2, 32'd3, 32'd5, 1'b0, 1'b0, 5'd9, 32'hFFFF_FFFE, 1'b0);
        send(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0, 5'd10, 32'h0FF0_0FF0, 1'b0);
        send(4'd6, 32'd1, 32'd31, 1'b0, 1'b0, 5'd11, 32'h8000_0000, 1'b0);
        send(4'd12, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd12, 32'd1, 1'b1);
        send(4'd13, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd13, 32'd0, 1'b0);
        send(4'd15, 32'd7, 32'd9, 1'b1, 1'b1, 5'd14, 32'd0, 1'b0);
        send(4'd0, 32'd7, 32'd9, 1'b1, 1'b1, 5'd15, 32'd0, 1'b0);
        idle(3);

        // Backpressure into the skid entry, then in-order drain.
        out_ready = 1'b0;
        send(4'd1, 32'd10, 32'd20, 1'b0, 1'b0, 5'd1, 32'd30, 1'b0);
        send(4'd5, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 1'b0, 5'd2, 32'h00F0_000F, 1'b0);
        chk("two_in_ready", {31'd0, in_ready}, 32'd0);
        chk("two_head_rd", {27'd0, out_rd}, 32'd1);
        idle(3);
        out_ready = 1'b1;
        idle(3);

        // Flush while full with a valid input presented.
        out_ready = 1'b0;
        send(4'd4, 32'h0000_1000, 32'h0000_0001, 1'b0, 1'b0, 5'd20, 32'h0000_1001, 1'b0);
        send(4'd1, 32'd1, 32'd1, 1'b0, 1'b0, 5'd21, 32'd2, 1'b0);
        in_valid = 1'b1; in_op = 4'd1; in_a = 32'd100; in_b = 32'd1; in_rd = 5'd22;
        in_is_branch = 1'b0; in_invert = 1'b0;
        cur_exp = '{res: 32'd101, tk: 1'b0, rd: 5'd22};
        flush = 1'b1;
        step(acc);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        idle(3);

        // Random stream with random backpressure and a mid-stream reset.
        accepted = 0;
        for (int cyc = 0; cyc < 2000 && accepted < 100; cyc++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_op        = 4'($urandom_range(0, 15));
            in_a         = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            in_b         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            in_is_branch = 1'($urandom_range(0, 1));
            in_invert    = 1'($urandom_range(0, 1));
            in_rd        = 5'($urandom_range(0, 31));
            out_ready    = 1'($urandom_range(0, 1));
            cur_exp.res  = model(in_op, in_a, in_b);
            cur_exp.tk   = in_is_branch && (in_op >= 4'd1) && (in_op <= 4'd13) && (cur_exp.res[0] ^ in_invert);
            cur_exp.rd   = in_rd;
            step(acc);
            if (acc) accepted++;
            if (accepted == 50 && acc) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("reset_async_out_valid", {31'd0, out_valid}, 32'd0);
                sb.delete();
                @(posedge clk);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
            end
        end
        if (accepted < 100) begin
            checks++; errors++;
            $display("FAIL stream_count: got %0d accepted, required 100", accepted);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(5);
        chk("drain_empty", sb.size(), 32'd0);
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
